// File: rtl/branch_update_issuer.sv
// Branch update issuer: matches fetch predictions against execute
// resolutions. Optional stat counters via BRANCH_UPDATE_STATS_EN.
package branch_update_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        is_br;
    logic        taken;
  } update_prediction_t;
endpackage

module branch_update_issuer
  import branch_update_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_valid,
  input  logic [31:0]        fetch_pc,
  input  logic               fetch_pred_taken,
  output logic               fetch_ready,
  input  logic               exe_valid,
  input  logic [31:0]        exe_pc,
  input  logic               exe_is_br,
  input  logic               exe_taken,
  input  logic [31:0]        exe_target,
  output logic               exe_ready,
  output update_prediction_t updateio,
  output logic               flush,
  output logic [31:0]        flush_pc
`ifdef BRANCH_UPDATE_STATS_EN
  ,
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_mispred
`endif
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state;
  state_t state_nxt;

  logic [32:0] mem [QUEUE_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        mismatch;
  logic [31:0] head_pc;
  logic        head_taken;

  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                 (wptr[AW] != rptr[AW]);
  assign empty = (wptr == rptr);
  assign push  = fetch_valid && fetch_ready;
  assign pop   = exe_valid && exe_ready;

  assign head_pc    = mem[rptr[AW-1:0]][32:1];
  assign head_taken = mem[rptr[AW-1:0]][0];

  assign mismatch = (head_pc != exe_pc) ||
                    (exe_is_br && (exe_taken != head_taken)) ||
                    (!exe_is_br && head_taken);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state: a bad pop redirects for exactly one cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (pop && mismatch) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Handshake and flush outputs decoded from state
  always_comb begin
    fetch_ready = 1'b0;
    exe_ready   = 1'b0;
    flush       = 1'b0;
    unique case (state)
      RUN: begin
        fetch_ready = !full;
        exe_ready   = !empty;
      end
      FLUSH:   flush = 1'b1;
      default: flush = 1'b0;
    endcase
  end

  // Record storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {fetch_pc, fetch_pred_taken};
  end

  // Pointers; a redirect drops every record, including one pushed now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (pop && mismatch) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Predictor update one cycle after each pop; fields hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      updateio <= '0;
    end else begin
      updateio.valid <= pop;
      if (pop) begin
        updateio.pc    <= exe_pc;
        updateio.is_br <= exe_is_br;
        updateio.taken <= exe_is_br && exe_taken;
      end
    end
  end

  // Capture redirect target at the mismatching pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pc <= '0;
    end else if (pop && mismatch) begin
      flush_pc <= (exe_is_br && exe_taken) ? exe_target
                                           : exe_pc + 32'd4;
    end
  end

`ifdef BRANCH_UPDATE_STATS_EN
  // Saturating branch and mispredict counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && exe_is_br && (stat_branches != '1))
        stat_branches <= stat_branches + 32'd1;
      if (pop && mismatch && (stat_mispred != '1))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule
